// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage register scoreboard.
// Each architectural register x1..x31 has a count of issued but not yet
// written-back writes. Decode is held on a RAW hazard against a pending
// register, or when the destination's pending count has reached MAX_PEND.
module id_hazard_ctrl #(
  parameter int unsigned MAX_PEND    = 3,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dec_valid,
  input  logic [4:0]             dec_rs1,
  input  logic [4:0]             dec_rs2,
  input  logic                   dec_use_rs1,
  input  logic                   dec_use_rs2,
  input  logic [4:0]             dec_rd,
  input  logic                   dec_wen,
  output logic                   issue_ready,
  output logic                   issue_fire,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic                   flush,
  output logic [31:0]            pending_mask,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   err
);

  localparam int unsigned   CW  = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] SAT = CW'(MAX_PEND);

  // Entry 0 exists only so register indices can address the array directly;
  // it is held at zero, which makes x0 never pending.
  logic [CW-1:0]          cnt_q [32];
  logic [CW-1:0]          cnt_d [32];
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   err_q, err_d;

  logic raw1, raw2, waw;

  // Hazard detection from registered counts only (no writeback bypass).
  always_comb begin
    raw1        = dec_use_rs1 && (dec_rs1 != 5'd0) && (cnt_q[dec_rs1] != '0);
    raw2        = dec_use_rs2 && (dec_rs2 != 5'd0) && (cnt_q[dec_rs2] != '0);
    waw         = dec_wen && (dec_rd != 5'd0) && (cnt_q[dec_rd] == SAT);
    issue_ready = !(raw1 || raw2 || waw);
    issue_fire  = dec_valid && issue_ready;
  end

  // Per-register count update: issue increments, writeback decrements,
  // both together cancel, flush clears; underflow flags a protocol error.
  always_comb begin
    err_d    = err_q;
    cnt_d[0] = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      logic inc, dec;
      inc      = issue_fire && dec_wen && (dec_rd == 5'(i));
      dec      = wb_valid && (wb_rd == 5'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec && !inc) begin
        if (cnt_q[i] == '0) err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CW'(1);
      end
      if (flush) cnt_d[i] = '0;
    end
  end

  // Saturating count of cycles in which a valid instruction is held.
  always_comb begin
    stall_d = stall_q;
    if (dec_valid && !issue_ready && (stall_q != '1)) stall_d = stall_q + STALL_CNT_W'(1);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) cnt_q[i] <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  // Output view of the registered state.
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 1; i < 32; i++) pending_mask[i] = (cnt_q[i] != '0);
    stall_cycles = stall_q;
    err          = err_q;
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: stimulus pushes hand-computed
// expectations tagged with a cycle number; a monitor pops and compares them
// at the falling edge of that cycle.
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid, dec_use_rs1, dec_use_rs2, dec_wen;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic        wb_valid, flush;
  logic        issue_ready, issue_fire, err;
  logic [31:0] pending_mask;
  logic [15:0] stall_cycles;

  id_hazard_ctrl #(.MAX_PEND(3), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_wen(dec_wen), .issue_ready(issue_ready),
    .issue_fire(issue_fire), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .pending_mask(pending_mask), .stall_cycles(stall_cycles), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic        rdy;
    logic        fire;
    logic [31:0] mask;
    logic [15:0] stall;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, want);
    end
  endtask

  // Monitor: compare the expectation scheduled for this cycle.
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].cyc < cyc) begin
      exp_t s;
      s = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d missed (now %0d)", s.name, s.cyc, cyc);
    end
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".ready"}, 32'(issue_ready),  32'(e.rdy));
      chk({e.name, ".fire"},  32'(issue_fire),   32'(e.fire));
      chk({e.name, ".mask"},  pending_mask,      e.mask);
      chk({e.name, ".stall"}, 32'(stall_cycles), 32'(e.stall));
      chk({e.name, ".err"},   32'(err),          32'(e.err));
    end
  end

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic w, input logic wv, input logic [4:0] wr, input logic fl);
    dec_valid = v;  dec_rs1 = r1; dec_use_rs1 = u1; dec_rs2 = r2; dec_use_rs2 = u2;
    dec_rd = rd;    dec_wen = w;  wb_valid = wv;    wb_rd = wr;   flush = fl;
  endtask

  task automatic expect_now(input string n, input logic r, input logic f,
                            input logic [31:0] m, input logic [15:0] s, input logic e);
    exp_t x;
    x.cyc = cyc; x.name = n; x.rdy = r; x.fire = f; x.mask = m; x.stall = s; x.err = e;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    // Held in reset: nothing pending, so a dependent read is ready.
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); expect_now("in_reset", 1, 1, 0, 0, 0); step();
    reset = 1'b1;

    // RAW on a single writer to x3
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); expect_now("A1_issue", 1, 1, 32'h0, 0, 0); step();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); expect_now("A2_raw",   0, 0, 32'h8, 0, 0); step();
    drive(1, 3, 1, 0, 0, 0, 0, 1, 3, 0); expect_now("A3_wb",    0, 0, 32'h8, 1, 0); step();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); expect_now("A4_rel",   1, 1, 32'h0, 2, 0); step();

    // x0 never pending
    drive(1, 0, 1, 0, 1, 0, 1, 0, 0, 0); expect_now("B1_x0", 1, 1, 0, 2, 0); step();
    drive(1, 0, 1, 0, 1, 0, 1, 0, 0, 0); expect_now("B2_x0", 1, 1, 0, 2, 0); step();

    // Saturation on x5
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); expect_now("C1", 1, 1, 32'h0,  2, 0); step();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); expect_now("C2", 1, 1, 32'h20, 2, 0); step();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); expect_now("C3", 1, 1, 32'h20, 2, 0); step();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); expect_now("C4_sat", 0, 0, 32'h20, 2, 0); step();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 5, 0); expect_now("C5_wb",  0, 0, 32'h20, 3, 0); step();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); expect_now("C6_rel", 1, 1, 32'h20, 4, 0); step();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); expect_now("C7_sat", 0, 0, 32'h20, 4, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0); expect_now("C8",  1, 0, 32'h20, 5, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0); expect_now("C9",  1, 0, 32'h20, 5, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0); expect_now("C10", 1, 0, 32'h20, 5, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_now("C11_drained", 1, 0, 32'h0, 5, 0); step();

    // Same-cycle issue and writeback to x7
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); expect_now("D1", 1, 1, 32'h0,  5, 0); step();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 7, 0); expect_now("D2", 1, 1, 32'h80, 5, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_now("D3_same", 1, 0, 32'h80, 5, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); expect_now("D4", 1, 0, 32'h80, 5, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_now("D5", 1, 0, 32'h0,  5, 0); step();

    // rs2 hazard, and use flags gating
    drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0); expect_now("R1", 1, 1, 32'h0,   5, 0); step();
    drive(1, 10, 0, 10, 1, 0, 0, 0, 0, 0); expect_now("R2_rs2", 0, 0, 32'h400, 5, 0); step();
    drive(1, 10, 0, 10, 0, 0, 0, 0, 0, 0); expect_now("R3_nouse", 1, 1, 32'h400, 6, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 10, 0); expect_now("R4", 1, 0, 32'h400, 6, 0); step();

    // Underflow error is sticky; wb to x0 ignored
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0); expect_now("E1_uf",  1, 0, 0, 6, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_now("E2_err", 1, 0, 0, 6, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); expect_now("E3_x0",  1, 0, 0, 6, 1); step();

    // Flush overrides same-cycle issue
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); expect_now("F1", 1, 1, 32'h0,  6, 1); step();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); expect_now("F2", 1, 1, 32'h8,  6, 1); step();
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); expect_now("F3", 1, 1, 32'h8,  6, 1); step();
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 1); expect_now("F4_flush", 1, 1, 32'h18, 6, 1); step();
    drive(1, 3, 1, 4, 1, 0, 0, 0, 0, 0); expect_now("F5_clear", 1, 1, 32'h0, 6, 1); step();

    // Reset mid-stall at stall_cycles = 10
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); expect_now("G_issue", 1, 1, 32'h0, 6, 1); step();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) expect_now("G_stall10", 0, 0, 32'h2, 16'd10, 1);
      step();
    end
    reset = 1'b0;
    expect_now("G_async_rst", 1, 1, 32'h0, 0, 0); step();
    expect_now("G_in_rst",    1, 1, 32'h0, 0, 0); step();
    reset = 1'b1;

    // Stall counter saturation
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); expect_now("S_issue", 1, 1, 32'h0, 0, 0); step();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 65540; k++) begin
      if (k == 2)     expect_now("S_first",  0, 0, 32'h2, 16'd1,   0);
      if (k == 65535) expect_now("S_fffe",   0, 0, 32'h2, 16'hFFFE, 0);
      if (k == 65536) expect_now("S_ffff",   0, 0, 32'h2, 16'hFFFF, 0);
      if (k == 65540) expect_now("S_hold",   0, 0, 32'h2, 16'hFFFF, 0);
      step();
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
